note_arbiter: RTL and testbench
===============================

NOTE_ARBITER -- requirements
Module: note_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the note register.
REQ-002 Parameter NOTE_W, default 4: note code width, equal to the width of the shared DFF bank.
REQ-003 Parameter HOLD_CYC, default 16: cycles a granted note is held; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_button  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  request per requester; level-sensitive.
REQ-007 note_in  input  N_REQ*NOTE_W  packed note codes; requester i at bits [i*NOTE_W+NOTE_W-1 : i*NOTE_W].
REQ-008 grant  output  N_REQ  one-hot owner of the note register; all-zero when idle.
REQ-009 reg_d  output  NOTE_W  data to the shared DFF bank D inputs.
REQ-010 reg_en  output  1  enable to the shared DFF bank EN input.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 note_valid  output  1  high while in HOLD; the bank holds a granted note.

Function
REQ-013 FSM states are IDLE, LOAD, HOLD and RELEASE, and all outputs are registered.
REQ-014 IDLE -> LOAD when any req bit is sampled high; otherwise stay in IDLE.
- In IDLE: grant=0, reg_en=0, reg_d=0.
REQ-015 Winner selection is round-robin.
- Search starts at index (last_grant+1) mod N_REQ and wraps.
- Pointer after reset: search starts at 0.
REQ-016 LOAD lasts exactly 1 cycle.
- grant = one-hot winner; reg_d = winner's note_in as sampled at the IDLE edge; reg_en=1.
REQ-017 LOAD -> HOLD unconditionally.
- In HOLD: reg_en=0, note_valid=1, grant held.
- Down-counter loads HOLD_CYC-1 on LOAD exit; width = clog2(HOLD_CYC+1).
REQ-018 HOLD -> RELEASE when the counter is 0 or the winner's req bit is sampled low, whichever comes first.
- HOLD_CYC=1 gives exactly one HOLD cycle.
REQ-019 RELEASE lasts 1 cycle: reg_en=1, reg_d=0 (silence code), grant held, note_valid=0.
REQ-020 RELEASE -> IDLE; on the same edge, last_grant is updated to the winner.
- grant returns to 0 in IDLE.
REQ-021 Full note latency: req high at edge k gives LOAD in cycle k+1.
- Uninterrupted busy span = HOLD_CYC+2 cycles.
- The next grant is earliest 1 IDLE cycle after RELEASE.
REQ-022 Changes to note_in after LOAD have no effect on reg_d.
REQ-023 Requests from non-winners during LOAD, HOLD or RELEASE are ignored, not queued.
- If still high, they are arbitrated on the next IDLE cycle.
REQ-024 grant is never multi-hot; reg_en is high only in LOAD and RELEASE.

Reset
REQ-025 When reset_button is sampled high, the next state is IDLE.
- Same cycle: grant=0, reg_d=0, reg_en=0, busy=0, note_valid=0, counter=0.
- Round-robin pointer is reset so requester 0 has highest priority.
REQ-026 Reset mid-operation (any state) aborts the note without issuing a RELEASE write.
- The shared DFF bank is cleared by its own reset_button input.
REQ-027 reset_button takes priority over all other inputs.

Structure
REQ-028 The state encoding typedef and the silence code constant (0) shall live in the shared package note_pkg.
REQ-029 The round-robin selector shall be a sub-module rr_pick (inputs: req, pointer; output: one-hot winner), instantiated once.
REQ-030 Counter, FSM and output registers shall reside in note_arbiter.

Verification
REQ-031 Reset then req=0001, note_in[3:0]=5 (HOLD_CYC=4).
- Expect LOAD 1 cycle with reg_d=5, reg_en=1; note_valid high 4 cycles; RELEASE with reg_d=0, reg_en=1; busy high 6 cycles.
REQ-032 req=1111 held continuously.
- Expect grants 0001, 0010, 0100, 1000, 0001 in successive notes, each separated by 1 IDLE cycle.
REQ-033 Winner's req drops in the 2nd HOLD cycle (HOLD_CYC=16).
- Expect RELEASE in the following cycle; note_valid high exactly 2 cycles.
REQ-034 note_in changes from 5 to 9 during HOLD.
- Expect reg_d stays 5 until RELEASE, then 0.
REQ-035 reset_button pulsed high in HOLD.
- Expect all outputs 0 next cycle, no RELEASE pulse.
- Next req=0010 with req=0001 also high: grant=0001, because the pointer was reset.
REQ-036 HOLD_CYC=1, req=0100.
- Expect LOAD, then 1 HOLD cycle, then RELEASE, then IDLE: busy high 3 cycles.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note arbiter: FSM state encoding and the
// code written to the note bank when a note is released.
package note_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_RELEASE = 2'd3
   } note_state_e;

   // Note code meaning "no note sounding".
   localparam int SILENCE_CODE = 0;

endpackage

// File: rtl/note_arbiter_rr_pick.sv
// Round-robin selector: picks the first asserted request at or after
// 'pointer', wrapping around, and returns it one-hot.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] pointer,
   output logic [N_REQ-1:0] winner
);

   logic [N_REQ-1:0] rot_req;
   logic [N_REQ-1:0] rot_win;
   logic             found;

   // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      rot_req = N_REQ'({req, req} >> pointer);
      rot_win = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (rot_req[i] && !found) begin
            rot_win[i] = 1'b1;
            found      = 1'b1;
         end
      end
      winner = N_REQ'(({rot_win, rot_win} << pointer) >> N_REQ);
   end

endmodule

// File: rtl/note_arbiter.sv
// Note arbiter: grants one requester at a time ownership of a shared note
// register bank. A note is loaded (LOAD), held for up to HOLD_CYC cycles
// (HOLD), then silenced (RELEASE). All outputs are registered.
module note_arbiter
   import note_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int NOTE_W   = 4,
   parameter int HOLD_CYC = 16
) (
   input  logic                    clk,
   input  logic                    reset_button,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*NOTE_W-1:0] note_in,
   output logic [N_REQ-1:0]        grant,
   output logic [NOTE_W-1:0]       reg_d,
   output logic                    reg_en,
   output logic                    busy,
   output logic                    note_valid
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(HOLD_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [NOTE_W-1:0] SILENCE  = NOTE_W'(SILENCE_CODE);

   note_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    ptr_next;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic                en_q, en_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [N_REQ-1:0]    winner;
   logic [NOTE_W-1:0]   sel_note;
   logic                win_req;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req     (req),
      .pointer (ptr_q),
      .winner  (winner)
   );

   // The current owner keeps the note only while its own request stays high.
   assign win_req = |(req & grant_q);

   // Note code of the round-robin winner (winner is one-hot or zero).
   always_comb begin
      sel_note = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner[i]) sel_note = note_in[i*NOTE_W +: NOTE_W];
      end
   end

   // Search start for the next arbitration: one past the current owner.
   always_comb begin
      ptr_next = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
   end

   // Next-state logic, hold counter and round-robin pointer update.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
         end
         ST_HOLD: begin
            if ((cnt_q == '0) || !win_req) state_d = ST_RELEASE;
            else                           cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            ptr_d   = ptr_next;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output values for the state being entered; registered below.
   always_comb begin
      grant_d = '0;
      note_d  = SILENCE;
      en_d    = 1'b0;
      valid_d = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      unique case (state_d)
         ST_LOAD: begin
            grant_d = winner;
            note_d  = sel_note;
            en_d    = 1'b1;
         end
         ST_HOLD: begin
            grant_d = grant_q;
            note_d  = note_q;
            valid_d = 1'b1;
         end
         ST_RELEASE: begin
            grant_d = grant_q;
            en_d    = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counter and pointer registers; reset aborts any note in flight.
   always_ff @(posedge clk) begin
      if (reset_button) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset_button) begin
         grant_q <= '0;
         note_q  <= SILENCE;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         grant_q <= grant_d;
         note_q  <= note_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign grant      = grant_q;
   assign reg_d      = note_q;
   assign reg_en     = en_q;
   assign busy       = busy_q;
   assign note_valid = valid_q;

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter: three instances with HOLD_CYC 4, 16, 1.
module tb_note_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req4, req16, req1;
   logic [15:0] note4, note16, note1;
   logic [3:0]  grant4, grant16, grant1;
   logic [3:0]  regd4, regd16, regd1;
   logic        en4, en16, en1;
   logic        busy4, busy16, busy1;
   logic        valid4, valid16, valid1;

   int n_checks = 0;
   int n_pass   = 0;

   note_arbiter #(.N_REQ(4), .NOTE_W(4), .HOLD_CYC(4)) dut4 (
      .clk(clk), .reset_button(rst), .req(req4), .note_in(note4),
      .grant(grant4), .reg_d(regd4), .reg_en(en4), .busy(busy4), .note_valid(valid4));

   note_arbiter #(.N_REQ(4), .NOTE_W(4), .HOLD_CYC(16)) dut16 (
      .clk(clk), .reset_button(rst), .req(req16), .note_in(note16),
      .grant(grant16), .reg_d(regd16), .reg_en(en16), .busy(busy16), .note_valid(valid16));

   note_arbiter #(.N_REQ(4), .NOTE_W(4), .HOLD_CYC(1)) dut1 (
      .clk(clk), .reset_button(rst), .req(req1), .note_in(note1),
      .grant(grant1), .reg_d(regd1), .reg_en(en1), .busy(busy1), .note_valid(valid1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; req4 = '0; req16 = '0; req1 = '0;
      note4 = '0; note16 = '0; note1 = '0;
      tick; tick;
      n_checks++; if (grant4 !== 4'b0000) $display("FAIL reset_grant: got %b expected %b", grant4, 4'b0000); else n_pass++;
      n_checks++; if (regd4 !== 4'h0) $display("FAIL reset_regd: got %h expected %h", regd4, 4'h0); else n_pass++;
      n_checks++; if (en4 !== 1'b0) $display("FAIL reset_en: got %b expected %b", en4, 1'b0); else n_pass++;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b expected %b", busy4, 1'b0); else n_pass++;
      n_checks++; if (valid4 !== 1'b0) $display("FAIL reset_valid: got %b expected %b", valid4, 1'b0); else n_pass++;
      n_checks++; if ({busy16, busy1} !== 2'b00) $display("FAIL reset_busy_others: got %b expected %b", {busy16, busy1}, 2'b00); else n_pass++;
   endtask

   task automatic test_single_note;
      int busy_cnt;
      busy_cnt = 0;
      rst = 1'b0; req4 = 4'b0001; note4 = 16'h0005;
      tick;
      if (busy4) busy_cnt++;
      n_checks++; if (grant4 !== 4'b0001) $display("FAIL single_load_grant: got %b expected %b", grant4, 4'b0001); else n_pass++;
      n_checks++; if (regd4 !== 4'h5) $display("FAIL single_load_regd: got %h expected %h", regd4, 4'h5); else n_pass++;
      n_checks++; if (en4 !== 1'b1) $display("FAIL single_load_en: got %b expected %b", en4, 1'b1); else n_pass++;
      n_checks++; if (valid4 !== 1'b0) $display("FAIL single_load_valid: got %b expected %b", valid4, 1'b0); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         tick;
         if (busy4) busy_cnt++;
         n_checks++; if (valid4 !== 1'b1) $display("FAIL single_hold%0d_valid: got %b expected %b", c, valid4, 1'b1); else n_pass++;
         n_checks++; if (en4 !== 1'b0) $display("FAIL single_hold%0d_en: got %b expected %b", c, en4, 1'b0); else n_pass++;
         n_checks++; if (regd4 !== 4'h5) $display("FAIL single_hold%0d_regd: got %h expected %h", c, regd4, 4'h5); else n_pass++;
      end
      tick;
      if (busy4) busy_cnt++;
      n_checks++; if (en4 !== 1'b1) $display("FAIL single_rel_en: got %b expected %b", en4, 1'b1); else n_pass++;
      n_checks++; if (regd4 !== 4'h0) $display("FAIL single_rel_regd: got %h expected %h", regd4, 4'h0); else n_pass++;
      n_checks++; if (valid4 !== 1'b0) $display("FAIL single_rel_valid: got %b expected %b", valid4, 1'b0); else n_pass++;
      n_checks++; if (grant4 !== 4'b0001) $display("FAIL single_rel_grant: got %b expected %b", grant4, 4'b0001); else n_pass++;
      req4 = 4'b0000;
      tick;
      if (busy4) busy_cnt++;
      n_checks++; if ({busy4, grant4} !== 5'b0) $display("FAIL single_idle: got %b expected %b", {busy4, grant4}, 5'b0); else n_pass++;
      n_checks++; if (busy_cnt !== 6) $display("FAIL single_busy_span: got %0d expected %0d", busy_cnt, 6); else n_pass++;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_g [5];
      logic [3:0] exp_n [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_n = '{4'h3, 4'h5, 4'h7, 4'h9, 4'h3};
      rst = 1'b1; req4 = '0;
      tick;
      rst = 1'b0; req4 = 4'b1111; note4 = 16'h9753;
      for (int n = 0; n < 5; n++) begin
         tick;
         n_checks++; if (grant4 !== exp_g[n]) $display("FAIL rr_grant%0d: got %b expected %b", n, grant4, exp_g[n]); else n_pass++;
         n_checks++; if (regd4 !== exp_n[n]) $display("FAIL rr_regd%0d: got %h expected %h", n, regd4, exp_n[n]); else n_pass++;
         repeat (5) tick;
         tick;
         n_checks++; if ({busy4, grant4} !== 5'b0) $display("FAIL rr_idle%0d: got %b expected %b", n, {busy4, grant4}, 5'b0); else n_pass++;
      end
      req4 = 4'b0000;
   endtask

   task automatic test_reset_mid_note;
      // Pointer now starts at requester 1 (last completed grant was 0).
      req4 = 4'b0010; note4 = 16'h0070;
      tick;
      n_checks++; if (grant4 !== 4'b0010) $display("FAIL rmid_load_grant: got %b expected %b", grant4, 4'b0010); else n_pass++;
      tick;
      n_checks++; if (valid4 !== 1'b1) $display("FAIL rmid_hold_valid: got %b expected %b", valid4, 1'b1); else n_pass++;
      rst = 1'b1; req4 = 4'b0000;
      tick;
      n_checks++; if (grant4 !== 4'b0000) $display("FAIL rmid_grant: got %b expected %b", grant4, 4'b0000); else n_pass++;
      n_checks++; if (regd4 !== 4'h0) $display("FAIL rmid_regd: got %h expected %h", regd4, 4'h0); else n_pass++;
      n_checks++; if (en4 !== 1'b0) $display("FAIL rmid_en: got %b expected %b", en4, 1'b0); else n_pass++;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL rmid_busy: got %b expected %b", busy4, 1'b0); else n_pass++;
      n_checks++; if (valid4 !== 1'b0) $display("FAIL rmid_valid: got %b expected %b", valid4, 1'b0); else n_pass++;
      rst = 1'b0; req4 = 4'b0011; note4 = 16'h0021;
      tick;
      n_checks++; if (grant4 !== 4'b0001) $display("FAIL rmid_ptr_grant: got %b expected %b", grant4, 4'b0001); else n_pass++;
      n_checks++; if (regd4 !== 4'h1) $display("FAIL rmid_ptr_regd: got %h expected %h", regd4, 4'h1); else n_pass++;
      req4 = 4'b0000;
      repeat (3) tick;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL rmid_drain_busy: got %b expected %b", busy4, 1'b0); else n_pass++;
   endtask

   task automatic test_note_change;
      req4 = 4'b0010; note4 = 16'h0050;
      tick;
      n_checks++; if (grant4 !== 4'b0010) $display("FAIL chg_load_grant: got %b expected %b", grant4, 4'b0010); else n_pass++;
      n_checks++; if (regd4 !== 4'h5) $display("FAIL chg_load_regd: got %h expected %h", regd4, 4'h5); else n_pass++;
      note4 = 16'h9999;
      for (int c = 0; c < 4; c++) begin
         tick;
         n_checks++; if (regd4 !== 4'h5) $display("FAIL chg_hold%0d_regd: got %h expected %h", c, regd4, 4'h5); else n_pass++;
      end
      tick;
      n_checks++; if ({en4, regd4} !== 5'b1_0000) $display("FAIL chg_rel: got %b expected %b", {en4, regd4}, 5'b1_0000); else n_pass++;
      req4 = 4'b0000;
      tick;
      n_checks++; if (busy4 !== 1'b0) $display("FAIL chg_idle_busy: got %b expected %b", busy4, 1'b0); else n_pass++;
   endtask

   task automatic test_early_release;
      int valid_cnt;
      valid_cnt = 0;
      req16 = 4'b0001; note16 = 16'h0006;
      tick;
      n_checks++; if (regd16 !== 4'h6) $display("FAIL early_load_regd: got %h expected %h", regd16, 4'h6); else n_pass++;
      tick;
      if (valid16) valid_cnt++;
      tick;
      if (valid16) valid_cnt++;
      req16 = 4'b0000;
      tick;
      if (valid16) valid_cnt++;
      n_checks++; if (en16 !== 1'b1) $display("FAIL early_rel_en: got %b expected %b", en16, 1'b1); else n_pass++;
      n_checks++; if (regd16 !== 4'h0) $display("FAIL early_rel_regd: got %h expected %h", regd16, 4'h0); else n_pass++;
      tick;
      if (valid16) valid_cnt++;
      n_checks++; if (busy16 !== 1'b0) $display("FAIL early_idle_busy: got %b expected %b", busy16, 1'b0); else n_pass++;
      n_checks++; if (valid_cnt !== 2) $display("FAIL early_valid_span: got %0d expected %0d", valid_cnt, 2); else n_pass++;
   endtask

   task automatic test_hold_one;
      int busy_cnt;
      busy_cnt = 0;
      req1 = 4'b0100; note1 = 16'h0A00;
      tick;
      if (busy1) busy_cnt++;
      n_checks++; if (grant1 !== 4'b0100) $display("FAIL h1_load_grant: got %b expected %b", grant1, 4'b0100); else n_pass++;
      n_checks++; if ({en1, regd1} !== 5'b1_1010) $display("FAIL h1_load: got %b expected %b", {en1, regd1}, 5'b1_1010); else n_pass++;
      tick;
      if (busy1) busy_cnt++;
      n_checks++; if ({valid1, en1} !== 2'b10) $display("FAIL h1_hold: got %b expected %b", {valid1, en1}, 2'b10); else n_pass++;
      tick;
      if (busy1) busy_cnt++;
      n_checks++; if ({valid1, en1, regd1} !== 6'b01_0000) $display("FAIL h1_rel: got %b expected %b", {valid1, en1, regd1}, 6'b01_0000); else n_pass++;
      req1 = 4'b0000;
      tick;
      if (busy1) busy_cnt++;
      n_checks++; if (busy_cnt !== 3) $display("FAIL h1_busy_span: got %0d expected %0d", busy_cnt, 3); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_single_note;
      test_round_robin;
      test_reset_mid_note;
      test_note_change;
      test_early_release;
      test_hold_one;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
